// File: rtl/msftdvip_mem_initiator.sv
// Purpose     : memory-port initiator; bridges a valid/ready request channel to the EN/ADDR/WE/BE/WDATA/IS_CAP port and returns responses on a valid/ready channel.
// Latency     : request -> mem_* is combinational; read data/error sampled 1 cycle after accept, presented on rsp_* the cycle after that.
// Backpressure: 2-entry response FIFO; req_ready_o/mem_en_o drop while FIFO occupancy plus the in-flight slot would exceed 2.
//
// Ports:
//   clk_i, rstn_i                   clock, asynchronous active-low reset
//   req_valid_i/req_ready_o + req_* upstream request (addr, we, be, is_cap, wdata)
//   rsp_valid_o/rsp_ready_i + rsp_* upstream response (rdata, err, we)
//   mem_*                           memory port; accept = mem_en_o & mem_ready_i
//
// Optional feature: define MSFTDVIP_MEM_INIT_TIMEOUT_EN to drop a request that has
// stalled on mem_ready_i=0 for TIMEOUT_CYCLES cycles and answer it with err=1.
module msftdvip_mem_initiator #(
    parameter int DATA_WIDTH     = 33,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    // request channel
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [31:0]           req_addr_i,
    input  logic                  req_we_i,
    input  logic [3:0]            req_be_i,
    input  logic                  req_is_cap_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    // response channel
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic                  rsp_we_o,
    // memory port
    output logic                  mem_en_o,
    output logic [31:0]           mem_addr_o,
    output logic                  mem_is_cap_o,
    output logic                  mem_we_o,
    output logic [3:0]            mem_be_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    input  logic                  mem_ready_i,
    input  logic                  mem_error_i
);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] rdata;
        logic                  err;
        logic                  we;
    } rsp_t;

    // response FIFO state
    rsp_t       fifo_q [2];
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] fifo_count;

    // one-cycle slot between acceptance and the FIFO push
    logic       inflight;
    logic       pend_local;   // locally generated error (misaligned or timed out)
    logic       pend_we;

    logic       aligned;
    logic       cap_ok;
    logic       word_ok;
    logic       space;
    logic [2:0] occ;
    logic       pop;
    logic       push;
    logic       accept;
    logic       local_take;
    logic       to_fire;
    logic       tag_clr;
    rsp_t       push_entry;

    // ------------------------------------------------------------------
    // Alignment: 64-bit caps need 8-byte alignment, everything else 4-byte.
    // ------------------------------------------------------------------
    assign word_ok = (req_addr_i[1:0] == 2'd0);
    assign cap_ok  = (DATA_WIDTH == 65) ? (req_addr_i[2:0] == 3'd0) : word_ok;
    assign aligned = req_is_cap_i ? cap_ok : word_ok;

    // ------------------------------------------------------------------
    // Slot accounting. A pop this cycle frees its slot immediately, which is
    // what lets back-to-back requests run at one per cycle.
    // ------------------------------------------------------------------
    assign rsp_valid_o = (fifo_count != 2'd0);
    assign pop         = rsp_valid_o & rsp_ready_i;
    assign occ         = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
    assign space       = (occ < 3'd2);

    // During a timeout pulse the stalled request is consumed locally, so the
    // memory port is held off and req_ready_o no longer waits on mem_ready_i.
    assign mem_en_o    = req_valid_i & space & aligned & ~to_fire;
    assign req_ready_o = space & ((aligned & ~to_fire) ? mem_ready_i : 1'b1);

    assign accept      = mem_en_o & mem_ready_i;
    assign local_take  = req_valid_i & space & (~aligned | to_fire);

    // ------------------------------------------------------------------
    // Request pass-through; non-cap writes must never set the tag bit.
    // ------------------------------------------------------------------
    assign tag_clr      = req_we_i & ~req_is_cap_i;
    assign mem_addr_o   = req_addr_i;
    assign mem_is_cap_o = req_is_cap_i;
    assign mem_we_o     = req_we_i;
    assign mem_be_o     = req_be_i;
    assign mem_wdata_o  = {req_wdata_i[DATA_WIDTH-1] & ~tag_clr, req_wdata_i[DATA_WIDTH-2:0]};

    // ------------------------------------------------------------------
    // Response formed from the memory sample one cycle after acceptance.
    // Writes and local errors always return zero data.
    // ------------------------------------------------------------------
    assign push             = inflight;
    assign push_entry.rdata = (pend_local | pend_we) ? '0 : mem_rdata_i;
    assign push_entry.err   = pend_local | mem_error_i;
    assign push_entry.we    = pend_we;

    assign rsp_rdata_o = fifo_q[rd_ptr].rdata;
    assign rsp_err_o   = fifo_q[rd_ptr].err;
    assign rsp_we_o    = fifo_q[rd_ptr].we;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            inflight   <= 1'b0;
            pend_local <= 1'b0;
            pend_we    <= 1'b0;
        end else begin
            inflight   <= accept | local_take;
            pend_local <= local_take;
            pend_we    <= req_we_i;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            fifo_q[0]  <= '0;
            fifo_q[1]  <= '0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            fifo_count <= 2'd0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr] <= push_entry;
                wr_ptr         <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            fifo_count <= fifo_count + {1'b0, push} - {1'b0, pop};
        end
    end

    // ------------------------------------------------------------------
    // Stall timeout. The counter holds the number of consecutive stalled
    // cycles; once it equals TIMEOUT_CYCLES the next cycle is the drop pulse,
    // and since mem_en_o is low in that cycle the counter clears itself.
    // ------------------------------------------------------------------
`ifdef MSFTDVIP_MEM_INIT_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] stall_cnt;

    assign to_fire = (stall_cnt == CW'(TIMEOUT_CYCLES));

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            stall_cnt <= '0;
        end else if (mem_en_o && !mem_ready_i) begin
            stall_cnt <= stall_cnt + CW'(1);
        end else begin
            stall_cnt <= '0;
        end
    end
`else
    logic unused_timeout;
    assign to_fire        = 1'b0;
    assign unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

endmodule

// File: doc/msftdvip_mem_initiator.md
MSFTDVIP_MEM_INITIATOR -- requirements
Module: msftdvip_mem_initiator

Interface
REQ-001 Parameter DATA_WIDTH, default 33, memory word width; legal values are 33 (32 data + tag) and 65 (64 data + tag).
REQ-002 Parameter TIMEOUT_CYCLES, default 256, stall limit in cycles; used only under REQ-030.
REQ-003 Port clk_i, input, 1, sole clock; all state updates on its rising edge.
REQ-004 Port rstn_i, input, 1, asynchronous active-low reset.
REQ-005 Upstream request ports: req_valid_i in 1; req_ready_o out 1; req_addr_i in 32; req_we_i in 1; req_be_i in 4; req_is_cap_i in 1; req_wdata_i in DATA_WIDTH.
REQ-006 Upstream response ports: rsp_valid_o out 1; rsp_ready_i in 1; rsp_rdata_o out DATA_WIDTH; rsp_err_o out 1; rsp_we_o out 1.
REQ-007 Memory ports: mem_en_o out 1; mem_addr_o out 32; mem_is_cap_o out 1; mem_we_o out 1; mem_be_o out 4; mem_wdata_o out DATA_WIDTH; mem_rdata_i in DATA_WIDTH; mem_ready_i in 1; mem_error_i in 1.

Function
REQ-008 The block SHALL be the initiator for the EN/ADDR/WE/BE/WDATA/IS_CAP memory port, bridging a valid/ready request channel and a valid/ready response channel.
REQ-009 Memory handshake: a request is accepted on a rising edge where mem_en_o and mem_ready_i are both 1.
REQ-010 Read data and mem_error_i SHALL be sampled exactly one cycle after acceptance, for both reads and writes.
REQ-011 The response buffer SHALL be a 2-entry FIFO holding {rdata, err, we}.
REQ-012 space = (fifo_count + inflight) < 2, where inflight = 1 in the cycle after an acceptance.
REQ-013 A response pop in the same cycle SHALL count as freeing one slot.
REQ-014 mem_en_o = req_valid_i & space & aligned.
REQ-015 req_ready_o = space & (aligned ? mem_ready_i : 1).
REQ-016 Address, control and data SHALL pass combinationally from req_* to mem_*, with zero added request latency.
REQ-017 Alignment: cap accesses need addr[2:0]==0 (DATA_WIDTH 65) or addr[1:0]==0 (DATA_WIDTH 33); word accesses need addr[1:0]==0.
REQ-018 A misaligned request SHALL NOT assert mem_en_o; it is consumed when space=1 and pushes {rdata=0, err=1, we=req_we_i} into the FIFO one cycle later.
REQ-019 For a non-cap write, mem_wdata_o[DATA_WIDTH-1] SHALL be forced to 0 (tag clear); all other bits pass through unchanged.
REQ-020 rsp_valid_o = (fifo_count != 0); rsp_rdata_o, rsp_err_o and rsp_we_o come from the FIFO head.
REQ-021 Pop on rsp_valid_o & rsp_ready_i; a simultaneous push and pop SHALL leave fifo_count unchanged.
REQ-022 Back-to-back accepts SHALL sustain 1 request/cycle while rsp_ready_i is held at 1.
REQ-023 Responses SHALL be returned in request order, including locally generated error responses.
REQ-024 rsp_rdata_o SHALL be 0 for write responses.

Reset
REQ-025 On rstn_i low: fifo_count=0, inflight=0, FIFO pointers=0, timeout counter=0.
REQ-026 Outputs under reset: rsp_valid_o=0; mem_en_o and req_ready_o follow REQ-014/REQ-015, with space=1.
REQ-027 If reset asserts mid-transaction, in-flight and buffered responses SHALL be discarded and no response emitted after deassertion.

Configuration
REQ-028 Macro MSFTDVIP_MEM_INIT_TIMEOUT_EN selects the stall-timeout feature.
REQ-029 Without the macro, mem_en_o MAY stall indefinitely on mem_ready_i=0.
REQ-030 With the macro, a stall counter SHALL count consecutive cycles with mem_en_o=1 and mem_ready_i=0, clearing on acceptance or when mem_en_o=0.
REQ-031 When the counter reaches TIMEOUT_CYCLES-1, in the next cycle req_ready_o SHALL pulse 1 with mem_en_o=0, the request is dropped, and an err=1 response is pushed one cycle later.

Verification
REQ-032 Reads 0x100 then 0x104, mem_ready_i=1, rsp_ready_i=1 -> two responses on consecutive cycles carrying the memory data, err=0, in order.
REQ-033 rsp_ready_i=0 with 4 queued reads -> exactly 2 accepted, req_ready_o=0 afterwards; raising rsp_ready_i drains both, then the remaining 2 are accepted.
REQ-034 Cap read at 0x204 with DATA_WIDTH=65 -> mem_en_o stays 0, one response with err=1 and rdata=0.
REQ-035 Word write of 0xDEADBEEF with tag=1 and is_cap=0 -> mem_wdata_o[32]=0 and [31:0]=0xDEADBEEF; response we=1, err=0, rdata=0.
REQ-036 mem_ready_i held 0 with the macro defined and TIMEOUT_CYCLES=8 -> request dropped after 8 stall cycles, err=1 response; without the macro, mem_en_o stays 1 for 100 cycles.
REQ-037 rstn_i pulsed low while 2 responses are buffered -> rsp_valid_o=0 immediately and no stale response after release.
